// File: rtl/l2_port_arbiter_if.sv
// Bundle of the I-cache, D-cache and shared L2 port signals.
// slave: arbiter view; master: L1/L2 environment view.
interface l2_port_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
);
    logic              i_read;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_wdata;
    logic [LINE_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  i_read, i_write, i_addr, i_wdata,
        output i_rdata, i_ready,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport master (
        output i_read, i_write, i_addr, i_wdata,
        input  i_rdata, i_ready,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/l2_port_arbiter.sv
// Two-way L1 I/D arbiter for a shared 128-bit L2 line port.
// L2_ARB_ROUND_ROBIN_EN: round-robin instead of D-priority + starve guard.
module l2_port_arbiter #(
    parameter int ADDR_W       = 28,
    parameter int LINE_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst_n,
    l2_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DRAIN
    } state_e;

    state_e            state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

`ifdef L2_ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_q, starve_d;
`endif

    logic req_i, req_d;
    logic pick_i;
    logic grant_i, grant_d;
    logic idle;

    assign req_i = bus.i_read | bus.i_write;
    assign req_d = bus.d_read | bus.d_write;
    assign idle  = (state_q == IDLE);

    // Tie-break used only when both sides request together.
`ifdef L2_ARB_ROUND_ROBIN_EN
    assign pick_i = last_d_q;
`else
    assign pick_i = (starve_q == LIMIT);
`endif

    assign grant_i = idle & req_i & (~req_d | pick_i);
    assign grant_d = idle & req_d & (~req_i | ~pick_i);

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef L2_ARB_ROUND_ROBIN_EN
        last_d_d    = last_d_q;
`else
        starve_d    = starve_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d     = BUSY_I;
                    mem_addr_d  = bus.i_addr;
                    mem_wdata_d = bus.i_wdata;
                    mem_write_d = bus.i_write;
                    mem_read_d  = bus.i_read & ~bus.i_write;
`ifdef L2_ARB_ROUND_ROBIN_EN
                    last_d_d    = 1'b0;
`else
                    starve_d    = '0;
`endif
                end else if (grant_d) begin
                    state_d     = BUSY_D;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    mem_write_d = bus.d_write;
                    mem_read_d  = bus.d_read & ~bus.d_write;
`ifdef L2_ARB_ROUND_ROBIN_EN
                    last_d_d    = 1'b1;
`else
                    if (!req_i)
                        starve_d = '0;
                    else if (starve_q != LIMIT)
                        starve_d = starve_q + 4'd1;
`endif
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ready) begin
                    state_d     = DRAIN;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef L2_ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b1;
`else
            starve_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef L2_ARB_ROUND_ROBIN_EN
            last_d_q    <= last_d_d;
`else
            starve_q    <= starve_d;
`endif
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Data is broadcast; only the owner's ready qualifies it.
    assign bus.i_rdata = bus.mem_rdata;
    assign bus.d_rdata = bus.mem_rdata;
    assign bus.i_ready = bus.mem_ready & (state_q == BUSY_I);
    assign bus.d_ready = bus.mem_ready & (state_q == BUSY_D);

    a_ready_excl : assert property (
        @(posedge clk) disable iff (!rst_n)
        !(bus.i_ready && bus.d_ready)
    );

    a_cmd_stable : assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q inside {BUSY_I, BUSY_D}) && !bus.mem_ready
        |=> $stable(mem_addr_q) && $stable(mem_wdata_q)
    );
endmodule

// File: tb/tb_l2_port_arbiter.sv
// Randomized scoreboard bench for l2_port_arbiter.
// Reference model predicts grants, commands and ready pulses.
module tb_l2_port_arbiter;
    localparam int AW    = 28;
    localparam int LW    = 128;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    l2_port_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    l2_port_arbiter #(
        .ADDR_W(AW),
        .LINE_W(LW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        bit            is_i;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        bit            rd;
        bit            wr;
        int            cyc;
    } cmd_t;

    typedef struct {
        bit            is_i;
        logic [LW-1:0] data;
        int            cyc;
    } rdy_t;

    cmd_t cmd_q[$];
    rdy_t rdy_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    // Agent 0 = I-cache, 1 = D-cache. st: 0 idle, 1 pending, 2 owned, 3 done
    int            ag_st[2];
    logic [AW-1:0] ag_addr[2];
    logic [LW-1:0] ag_wd[2];
    bit            ag_rd[2];
    bit            ag_wr[2];

    // Reference model: 0 free, 1 busy, 2 drain
    int phase;
    int lat;
    int owner;
    int streak;
    bit last_d;
    int grants_i;
    int grants_d;

    function automatic void chk(string name, logic [LW-1:0] act,
                                logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_agents();
        bus.i_read  = ag_rd[0];
        bus.i_write = ag_wr[0];
        bus.i_addr  = ag_addr[0];
        bus.i_wdata = ag_wd[0];
        bus.d_read  = ag_rd[1];
        bus.d_write = ag_wr[1];
        bus.d_addr  = ag_addr[1];
        bus.d_wdata = ag_wd[1];
    endtask

    task automatic model_reset();
        phase    = 0;
        lat      = 0;
        owner    = 0;
        streak   = 0;
        last_d   = 1'b1;
        grants_i = 0;
        grants_d = 0;
        cmd_q.delete();
        rdy_q.delete();
        for (int a = 0; a < 2; a++) begin
            ag_st[a]   = 0;
            ag_rd[a]   = 1'b0;
            ag_wr[a]   = 1'b0;
            ag_addr[a] = '0;
            ag_wd[a]   = '0;
        end
        drive_agents();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
    endtask

    // Winner under the arbitration rules when both or one request.
    function automatic bit pick_i(bit ri, bit rd);
        bit w;
        if (ri && rd) begin
`ifdef L2_ARB_ROUND_ROBIN_EN
            w = last_d;
`else
            w = (streak == LIMIT);
`endif
        end else begin
            w = ri;
        end
`ifdef L2_ARB_ROUND_ROBIN_EN
        last_d = !w;
`else
        if (w || !ri) streak = 0;
        else if (streak < LIMIT) streak = streak + 1;
`endif
        return w;
    endfunction

    task automatic step(int p_req);
        int   k;
        bit   ri;
        bit   rq;
        bit   w;
        cmd_t c;
        rdy_t r;
        @(negedge clk);
        cyc++;
        for (int a = 0; a < 2; a++) begin
            if (ag_st[a] == 3) ag_st[a] = 0;
            if (ag_st[a] == 0 && int'($urandom_range(99)) < p_req) begin
                ag_st[a]   = 1;
                ag_addr[a] = AW'($urandom);
                ag_wd[a]   = rnd_line();
                k          = int'($urandom_range(2));
                ag_rd[a]   = (k != 1);
                ag_wr[a]   = (k != 0);
            end else if (ag_st[a] == 2) begin
                // Owner's inputs are don't-care once granted.
                ag_addr[a] = AW'($urandom);
                ag_wd[a]   = rnd_line();
                ag_rd[a]   = 1'($urandom);
                ag_wr[a]   = 1'($urandom);
            end else if (ag_st[a] == 0) begin
                ag_rd[a]   = 1'b0;
                ag_wr[a]   = 1'b0;
                ag_addr[a] = AW'($urandom);
            end
        end
        drive_agents();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = rnd_line();
        case (phase)
            0: begin
                bus.mem_ready = ($urandom_range(9) == 0);
                ri = (ag_st[0] == 1);
                rq = (ag_st[1] == 1);
                if (ri || rq) begin
                    w       = pick_i(ri, rq);
                    owner   = w ? 0 : 1;
                    c.is_i  = w;
                    c.addr  = ag_addr[owner];
                    c.wdata = ag_wd[owner];
                    c.wr    = ag_wr[owner];
                    c.rd    = ag_rd[owner] & ~ag_wr[owner];
                    c.cyc   = cyc;
                    cmd_q.push_back(c);
                    ag_st[owner] = 2;
                    if (w) grants_i++;
                    else grants_d++;
                    phase = 1;
                    lat   = int'($urandom_range(1, 6));
                end
            end
            1: begin
                lat--;
                if (lat == 0) begin
                    bus.mem_ready = 1'b1;
                    r.is_i = (owner == 0);
                    r.data = bus.mem_rdata;
                    r.cyc  = cyc;
                    rdy_q.push_back(r);
                    ag_st[owner] = 3;
                    phase = 2;
                end
            end
            default: begin
                bus.mem_ready = ($urandom_range(2) == 0);
                phase = 0;
            end
        endcase
    endtask

    // Monitor: compares observed DUT outputs against queued expectations.
    bit   prev_active = 1'b0;
    bit   have_cur    = 1'b0;
    bit   exp_clear   = 1'b0;
    cmd_t cur;

    initial begin : monitor
        bit   active;
        rdy_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                active = bus.mem_read | bus.mem_write;
                if (exp_clear) begin
                    chk("cmd_clear", LW'(active), '0);
                    exp_clear = 1'b0;
                end
                if (active && !prev_active) begin
                    if (cmd_q.size() == 0) begin
                        chk("cmd_unexpected", LW'(active), '0);
                    end else begin
                        cur      = cmd_q.pop_front();
                        have_cur = 1'b1;
                        chk("cmd_latency", LW'(cyc), LW'(cur.cyc + 1));
                        chk("cmd_addr", LW'(bus.mem_addr), LW'(cur.addr));
                        chk("cmd_read", LW'(bus.mem_read), LW'(cur.rd));
                        chk("cmd_write", LW'(bus.mem_write), LW'(cur.wr));
                        if (cur.wr)
                            chk("cmd_wdata", bus.mem_wdata, cur.wdata);
                    end
                end else if (active && have_cur) begin
                    chk("hold_addr", LW'(bus.mem_addr), LW'(cur.addr));
                    chk("hold_rw", LW'({bus.mem_read, bus.mem_write}),
                        LW'({cur.rd, cur.wr}));
                end
                if (!active && cmd_q.size() != 0
                    && cmd_q[0].cyc < cyc - 1) begin
                    chk("cmd_missing", LW'(cmd_q[0].cyc), LW'(cyc - 1));
                    void'(cmd_q.pop_front());
                end
                if (bus.i_ready || bus.d_ready) begin
                    if (rdy_q.size() == 0) begin
                        chk("stray_ready", LW'({bus.i_ready, bus.d_ready}), '0);
                    end else begin
                        e = rdy_q.pop_front();
                        chk("ready_cycle", LW'(cyc), LW'(e.cyc));
                        chk("ready_who", LW'({bus.i_ready, bus.d_ready}),
                            LW'({e.is_i, !e.is_i}));
                        chk("ready_data",
                            e.is_i ? bus.i_rdata : bus.d_rdata, e.data);
                        exp_clear = 1'b1;
                    end
                end else if (rdy_q.size() != 0 && rdy_q[0].cyc <= cyc) begin
                    e = rdy_q.pop_front();
                    chk("ready_missing", '0, LW'(1));
                end
                prev_active = active;
            end
        end
    end

    task automatic rand_reset();
        @(negedge clk);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        prev_active = 1'b0;
        have_cur    = 1'b0;
        exp_clear   = 1'b0;
        mon_en      = 1'b1;
    endtask

    initial begin : stim
        int n;
        model_reset();
        // Reset holds mem_* at zero despite a pending D read.
        rst_n       = 1'b0;
        bus.d_read  = 1'b1;
        bus.d_addr  = 28'h1234567;
        bus.d_wdata = rnd_line();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_mem_read", LW'(bus.mem_read), '0);
        chk("rst_mem_write", LW'(bus.mem_write), '0);
        chk("rst_mem_addr", LW'(bus.mem_addr), '0);
        chk("rst_mem_wdata", bus.mem_wdata, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_read", LW'(bus.mem_read), LW'(1));
        chk("post_rst_addr", LW'(bus.mem_addr), LW'(28'h1234567));
        // Reset mid BUSY_D abandons the transaction.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        bus.d_read = 1'b0;
        chk("abort_read", LW'(bus.mem_read), '0);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rnd_line();
        #1;
        chk("abort_d_ready", LW'(bus.d_ready), '0);
        chk("abort_i_ready", LW'(bus.i_ready), '0);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        chk("abort_idle_cmd", LW'(bus.mem_read | bus.mem_write), '0);

        // Saturated contention exercises the starvation guard.
        rand_reset();
        repeat (300) step(100);
        chk("contention_i_grants", LW'(grants_i > 0), LW'(1));
        repeat (500) step(40);
        repeat (200) step(10);
        rand_reset();
        repeat (300) step(70);

        n = 0;
        while ((phase != 0 || ag_st[0] != 0 || ag_st[1] != 0) && n < 60) begin
            step(0);
            n++;
        end
        chk("drain_timeout", LW'(n < 60), LW'(1));
        repeat (3) step(0);
        chk("cmd_q_empty", LW'(cmd_q.size()), '0);
        chk("rdy_q_empty", LW'(rdy_q.size()), '0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
